// File: rtl/clock_gate_bank.sv
// Bank of independently gated copies of one clock, each channel's enable
// synchronised, held for minimum on/off dwell times, then acknowledged.

module BUFGCE (
    input  logic I,
    input  logic CE,
    output logic O
);
    logic ce_l;

    // CE is captured while I is low, so O can only start or stop on a full pulse
    always_latch begin
        if (!I) ce_l <= CE;
    end

    assign O = I & ce_l;
endmodule

module clock_gate_bank #(
    parameter int N_CH           = 4,
    parameter int SYNC_STAGES    = 2,
    parameter int MIN_ON_CYCLES  = 4,
    parameter int MIN_OFF_CYCLES = 4
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic [N_CH-1:0] en_req,
    output logic [N_CH-1:0] clk_gated,
    output logic [N_CH-1:0] gate_ce,
    output logic [N_CH-1:0] en_ack,
    output logic [N_CH-1:0] busy
);
    localparam int MAX_DWELL = (MIN_ON_CYCLES > MIN_OFF_CYCLES) ?
                               MIN_ON_CYCLES : MIN_OFF_CYCLES;
    localparam int CNT_W = $clog2(MAX_DWELL + 1);

    localparam logic [CNT_W-1:0] ON_LIM  = CNT_W'(MIN_ON_CYCLES);
    localparam logic [CNT_W-1:0] OFF_LIM = CNT_W'(MIN_OFF_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic {
        OFF = 1'b0,
        ON  = 1'b1
    } state_t;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync;
        logic                   req_s;
        state_t                 state;
        logic [CNT_W-1:0]       cnt;
        logic                   ce;
        logic                   ack;
        logic                   bsy;

        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) sync <= '0;
            else         sync <= {sync[SYNC_STAGES-2:0], en_req[i]};
        end

        assign req_s = sync[SYNC_STAGES-1];

        // cnt counts cycles spent in the current state, entry cycle included
        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                state <= OFF;
                cnt   <= OFF_LIM;
                ce    <= 1'b0;
            end else begin
                unique case (state)
                    OFF: begin
                        if (req_s && cnt == OFF_LIM) begin
                            state <= ON;
                            ce    <= 1'b1;
                            cnt   <= CNT_ONE;
                        end else if (cnt != OFF_LIM) begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                    ON: begin
                        if (!req_s && cnt == ON_LIM) begin
                            state <= OFF;
                            ce    <= 1'b0;
                            cnt   <= CNT_ONE;
                        end else if (cnt != ON_LIM) begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                    default: begin
                        state <= OFF;
                        ce    <= 1'b0;
                        cnt   <= OFF_LIM;
                    end
                endcase
            end
        end

        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                ack <= 1'b0;
                bsy <= 1'b0;
            end else begin
                ack <= ce;
                bsy <= req_s ^ ack;
            end
        end

        assign gate_ce[i] = ce;
        assign en_ack[i]  = ack;
        assign busy[i]    = bsy;

        BUFGCE u_bufgce (
            .I  (clk),
            .CE (ce),
            .O  (clk_gated[i])
        );
    end
endmodule

// File: tb/tb_clock_gate_bank.sv
// Self-checking bench for clock_gate_bank: directed scenarios plus random
// requests compared against a history-based behavioural model.

module tb_clock_gate_bank;
    localparam int N       = 4;
    localparam int SYNC    = 2;
    localparam int MIN_ON  = 4;
    localparam int MIN_OFF = 4;
    localparam int HALF    = 5;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic [N-1:0] en_req = '0;
    logic [N-1:0] clk_gated;
    logic [N-1:0] gate_ce;
    logic [N-1:0] en_ack;
    logic [N-1:0] busy;

    int vectors = 0;
    int miscompares = 0;
    int runts = 0;
    int grises = 0;

    clock_gate_bank #(
        .N_CH           (N),
        .SYNC_STAGES    (SYNC),
        .MIN_ON_CYCLES  (MIN_ON),
        .MIN_OFF_CYCLES (MIN_OFF)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .en_req    (en_req),
        .clk_gated (clk_gated),
        .gate_ce   (gate_ce),
        .en_ack    (en_ack),
        .busy      (busy)
    );

    always #HALF clk = ~clk;

    // Reference model: req_s is en_req from SYNC edges ago; the gate flips
    // toward req_s once it has dwelt long enough in its current level.
    logic [N-1:0] hist[$];
    logic [N-1:0] m_req = '0;
    logic [N-1:0] m_ce = '0;
    logic [N-1:0] m_ack = '0;
    logic [N-1:0] m_busy = '0;
    logic [N-1:0] m_gclk = '0;
    int           dwell[N];

    always @(posedge clk or negedge resetn) begin
        logic [N-1:0] nxt;
        if (!resetn) begin
            hist.delete();
            m_req  = '0;
            m_ce   = '0;
            m_ack  = '0;
            m_busy = '0;
            m_gclk = '0;
            for (int c = 0; c < N; c++) dwell[c] = MIN_OFF;
        end else begin
            nxt = m_ce;
            for (int c = 0; c < N; c++) begin
                if (m_req[c] != m_ce[c] &&
                    dwell[c] >= (m_ce[c] ? MIN_ON : MIN_OFF)) begin
                    nxt[c]   = ~m_ce[c];
                    dwell[c] = 1;
                end else if (dwell[c] < 1000) begin
                    dwell[c]++;
                end
            end
            m_gclk = m_ce;
            m_busy = m_req ^ m_ack;
            m_ack  = m_ce;
            m_ce   = nxt;
            hist.push_front(en_req);
            if (hist.size() > SYNC) void'(hist.pop_back());
            m_req = (hist.size() == SYNC) ? hist[SYNC-1] : '0;
        end
    end

    // Every gated high pulse must last exactly one clk high phase
    logic [N-1:0] gprev = '0;
    time          rise_t[N];

    always @(clk_gated) begin
        for (int c = 0; c < N; c++) begin
            if (clk_gated[c] === 1'b1 && gprev[c] !== 1'b1) begin
                rise_t[c] = $time;
                grises++;
            end else if (clk_gated[c] !== 1'b1 && gprev[c] === 1'b1) begin
                if (($time - rise_t[c]) != HALF) runts++;
            end
        end
        gprev = clk_gated;
    end

    task automatic test_reset();
        int g0;
        resetn = 1'b0;
        en_req = '0;
        repeat (3) @(negedge clk);
        #1;
        vectors++;
        if ({gate_ce, en_ack, busy} !== '0) begin
            miscompares++;
            $display("FAIL reset_hold: got %h want 0", {gate_ce, en_ack, busy});
        end
        @(negedge clk);
        resetn = 1'b1;
        g0 = grises;
        repeat (20) begin
            @(negedge clk);
            #1;
            vectors++;
            if ({gate_ce, en_ack, busy} !== '0) begin
                miscompares++;
                $display("FAIL reset_idle: got %h want 0",
                         {gate_ce, en_ack, busy});
            end
        end
        vectors++;
        if (grises != g0) begin
            miscompares++;
            $display("FAIL reset_no_gclk: got %0d edges want 0", grises - g0);
        end
    endtask

    task automatic test_enable_latency();
        int lat = 0;
        @(negedge clk);
        en_req[0] = 1'b1;
        while (!gate_ce[0] && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        vectors++;
        if (lat != SYNC + 1) begin
            miscompares++;
            $display("FAIL en_latency: got %0d want %0d", lat, SYNC + 1);
        end
        vectors++;
        if (en_ack[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL ack_early: got %b want 0", en_ack[0]);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (en_ack[0] !== 1'b1 || clk_gated[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL ack_gclk: got ack=%b gclk=%b want 1 1",
                     en_ack[0], clk_gated[0]);
        end
    endtask

    task automatic test_min_on();
        int n = 0;
        int hi = 0;
        @(negedge clk);
        en_req[1] = 1'b1;
        @(negedge clk);
        en_req[1] = 1'b0;
        while (!gate_ce[1] && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        while (gate_ce[1] && hi < 20) begin
            hi++;
            if (hi == 3 || hi == 4) begin
                vectors++;
                if (busy[1] !== 1'b1) begin
                    miscompares++;
                    $display("FAIL busy_dwell: got %b want 1 at cycle %0d",
                             busy[1], hi);
                end
            end
            @(posedge clk);
            #1;
        end
        vectors++;
        if (hi != MIN_ON) begin
            miscompares++;
            $display("FAIL min_on: got %0d cycles want %0d", hi, MIN_ON);
        end
        vectors++;
        if (gate_ce[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL ch0_steady: got %b want 1", gate_ce[0]);
        end
    endtask

    task automatic test_min_off();
        int n = 0;
        int lo = 1;
        @(negedge clk);
        en_req[2] = 1'b1;
        repeat (12) @(negedge clk);
        en_req[2] = 1'b0;
        while (gate_ce[2] && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        @(negedge clk);
        en_req[2] = 1'b1;
        while (!gate_ce[2] && lo < 30) begin
            @(posedge clk);
            #1;
            if (!gate_ce[2]) lo++;
        end
        vectors++;
        if (lo < MIN_OFF || !gate_ce[2]) begin
            miscompares++;
            $display("FAIL min_off: got %0d low cycles ce=%b want >=%0d then 1",
                     lo, gate_ce[2], MIN_OFF);
        end
        vectors++;
        if (gate_ce[1:0] !== 2'b01) begin
            miscompares++;
            $display("FAIL others_steady: got %b want 01", gate_ce[1:0]);
        end
    endtask

    task automatic test_all_same_edge();
        int lat = 0;
        @(negedge clk);
        en_req = '0;
        repeat (20) @(negedge clk);
        vectors++;
        if (gate_ce !== '0) begin
            miscompares++;
            $display("FAIL all_off: got %h want 0", gate_ce);
        end
        en_req = '1;
        while (gate_ce == '0 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        vectors++;
        if (gate_ce !== 4'hF || lat != SYNC + 1) begin
            miscompares++;
            $display("FAIL all_rise: got ce=%h lat=%0d want F %0d",
                     gate_ce, lat, SYNC + 1);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (en_ack !== 4'hF) begin
            miscompares++;
            $display("FAIL all_ack: got %h want F", en_ack);
        end
    endtask

    task automatic test_reset_mid_on();
        int lat = 0;
        @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        vectors++;
        if ({gate_ce, en_ack, busy} !== '0) begin
            miscompares++;
            $display("FAIL mid_reset: got %h want 0", {gate_ce, en_ack, busy});
        end
        vectors++;
        if (clk_gated[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_reset_pulse_cut: got %b want 1", clk_gated[0]);
        end
        @(negedge clk);
        #1;
        vectors++;
        if (clk_gated !== '0) begin
            miscompares++;
            $display("FAIL mid_reset_stop: got %h want 0", clk_gated);
        end
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        while (!gate_ce[0] && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        vectors++;
        if (lat != SYNC + 1) begin
            miscompares++;
            $display("FAIL reenable: got %0d want %0d", lat, SYNC + 1);
        end
        vectors++;
        if (runts != 0) begin
            miscompares++;
            $display("FAIL runt_pulse: got %0d want 0", runts);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            @(posedge clk);
            #1;
            vectors++;
            if (clk_gated !== m_gclk) begin
                miscompares++;
                $display("FAIL rnd_gclk: got %h want %h", clk_gated, m_gclk);
            end
            @(negedge clk);
            #1;
            vectors++;
            if (gate_ce !== m_ce) begin
                miscompares++;
                $display("FAIL rnd_ce: got %h want %h", gate_ce, m_ce);
            end
            vectors++;
            if (en_ack !== m_ack) begin
                miscompares++;
                $display("FAIL rnd_ack: got %h want %h", en_ack, m_ack);
            end
            vectors++;
            if (busy !== m_busy) begin
                miscompares++;
                $display("FAIL rnd_busy: got %h want %h", busy, m_busy);
            end
            for (int c = 0; c < N; c++)
                if ($urandom_range(0, 3) == 0) en_req[c] = ~en_req[c];
        end
        vectors++;
        if (runts != 0) begin
            miscompares++;
            $display("FAIL rnd_runt: got %0d want 0", runts);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_enable_latency();
        test_min_on();
        test_min_off();
        test_all_same_edge();
        test_reset_mid_on();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
